tdc_channel_arbiter: RTL and testbench



---
 rtl/tdc_channel_arbiter_if.sv | 29 ++
 rtl/tdc_channel_arbiter.sv | 128 ++++++++++++
 tb/tb_tdc_channel_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_channel_arbiter_if.sv
// rtl/tdc_channel_arbiter_if.sv - channel inputs and FIFO write port of the TDC arbiter
interface tdc_channel_arbiter_if #(
    parameter int N_CH     = 4,
    parameter int TS_WIDTH = 56
);
    logic [N_CH-1:0]          ch_valid;
    logic [N_CH*TS_WIDTH-1:0] ch_timestamp;
    logic [63:0]              fifo_din;
    logic                     fifo_wr_en;
    logic                     fifo_full;

    // arbiter side: consumes channel strobes, drives the FIFO write port
    modport master (
        input  ch_valid,
        input  ch_timestamp,
        input  fifo_full,
        output fifo_din,
        output fifo_wr_en
    );

    // environment side: channels and FIFO
    modport slave (
        output ch_valid,
        output ch_timestamp,
        output fifo_full,
        input  fifo_din,
        input  fifo_wr_en
    );
endinterface

// File: rtl/tdc_channel_arbiter.sv
// rtl/tdc_channel_arbiter.sv - round-robin merge of N_CH TDC channels into one 64-bit FIFO port
module tdc_channel_arbiter #(
    parameter int N_CH     = 4,
    parameter int TS_WIDTH = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clr,
    tdc_channel_arbiter_if.master bus,
    output logic                  busy,
    output logic [N_CH-1:0]       drop_flags,
    output logic [31:0]           drop_count,
    output logic [31:0]           word_count
);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    if (TS_WIDTH + 8 != 64) begin : g_bad_width
        $error("tdc_channel_arbiter: TS_WIDTH + 8 must equal 64");
    end
    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("tdc_channel_arbiter: N_CH must be in 1..16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [N_CH-1:0]       pend;
    logic [TS_WIDTH-1:0]   hold [N_CH];
    logic [PW-1:0]         rr_ptr;

    logic                  can_grant;
    logic                  gnt_vld;
    logic [PW-1:0]         gnt_idx;
    logic [N_CH-1:0]       gnt_onehot;
    logic                  run_ok;
    logic [N_CH-1:0]       cap;
    logic [N_CH-1:0]       drop;
    logic [32:0]           drop_sum;

    assign can_grant = (state != IDLE) && !bus.fifo_full && !clr;
    assign run_ok    = (state == RUN) && !clr;
    assign busy      = (state != IDLE);

    // round-robin search starting one past the last granted channel
    always_comb begin
        logic [PW-1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        if (can_grant) begin
            for (int i = 1; i <= N_CH; i++) begin
                idx = PW'((int'(rr_ptr) + i) % N_CH);
                if (!gnt_vld && pend[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
    end

    // a slot being granted this cycle counts as free, so back-to-back strobes never drop
    always_comb begin
        gnt_onehot = gnt_vld ? (N_CH'(1) << gnt_idx) : '0;
        cap  = bus.ch_valid & ~(pend & ~gnt_onehot) & {N_CH{run_ok}};
        drop = bus.ch_valid &  (pend & ~gnt_onehot) & {N_CH{run_ok}};
        drop_sum = {1'b0, drop_count} + 33'($countones(drop));
    end

    // FIFO write port driven straight from the grant
    always_comb begin
        bus.fifo_wr_en = gnt_vld;
        bus.fifo_din   = gnt_vld ? {8'(gnt_idx), hold[gnt_idx]} : 64'd0;
    end

    // enable/drain sequencing; clr dominates everything
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state_nxt = RUN;
                RUN:     if (!enable) state_nxt = DRAIN;
                DRAIN: begin
                    if (enable)             state_nxt = RUN;
                    else if (!(|pend) && !gnt_vld) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // pending slots, round-robin pointer and stats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= '0;
            rr_ptr     <= PW'(N_CH - 1);
            drop_flags <= '0;
            drop_count <= '0;
            word_count <= '0;
            for (int k = 0; k < N_CH; k++) hold[k] <= '0;
        end else if (clr) begin
            pend       <= '0;
            rr_ptr     <= PW'(N_CH - 1);
            drop_flags <= '0;
            drop_count <= '0;
            word_count <= '0;
        end else begin
            pend <= (pend & ~gnt_onehot) | cap;
            for (int k = 0; k < N_CH; k++) begin
                if (cap[k]) hold[k] <= bus.ch_timestamp[k*TS_WIDTH +: TS_WIDTH];
            end
            if (gnt_vld) begin
                rr_ptr     <= gnt_idx;
                word_count <= word_count + 32'd1;
            end
            drop_flags <= drop_flags | drop;
            drop_count <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
    end
endmodule

// File: tb/tb_tdc_channel_arbiter.sv
// tb/tb_tdc_channel_arbiter.sv - directed bench with behavioural model for tdc_channel_arbiter
module tb_tdc_channel_arbiter;
    localparam int N  = 4;
    localparam int TW = 56;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic clr = 1'b0;
    logic busy;
    logic [N-1:0] drop_flags;
    logic [31:0] drop_count;
    logic [31:0] word_count;

    int n_cmp = 0;
    int n_err = 0;

    tdc_channel_arbiter_if #(.N_CH(N), .TS_WIDTH(TW)) bus ();

    tdc_channel_arbiter #(.N_CH(N), .TS_WIDTH(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clr        (clr),
        .bus        (bus),
        .busy       (busy),
        .drop_flags (drop_flags),
        .drop_count (drop_count),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // behavioural model: mode 0 idle, 1 accepting, 2 draining
    int          m_mode;
    bit          m_pend [N];
    logic [TW-1:0] m_hold [N];
    int          m_last;
    bit [N-1:0]  m_flags;
    longint      m_drops;
    bit [31:0]   m_words;

    task automatic model_reset();
        m_mode = 0;
        m_last = N - 1;
        m_flags = '0;
        m_drops = 0;
        m_words = '0;
        for (int k = 0; k < N; k++) begin
            m_pend[k] = 1'b0;
            m_hold[k] = '0;
        end
    endtask

    initial model_reset();

    // compare DUT against model every cycle, then advance the model on the same inputs
    always @(negedge clk) begin
        int  g;
        bit  pre [N];
        bit  any_p;
        int  nd;
        logic [63:0] exp_din;
        if (rst) begin
            model_reset();
            chk("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
            chk("rst_din", bus.fifo_din, 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_word_count", 64'(word_count), 64'd0);
        end else begin
            g = -1;
            if (m_mode != 0 && !bus.fifo_full && !clr) begin
                for (int i = 1; i <= N; i++) begin
                    int c;
                    c = (m_last + i) % N;
                    if (g < 0 && m_pend[c]) g = c;
                end
            end
            exp_din = (g >= 0) ? {8'(g), m_hold[g]} : 64'd0;
            chk("wr_en", 64'(bus.fifo_wr_en), 64'(g >= 0));
            chk("din", bus.fifo_din, exp_din);
            chk("busy", 64'(busy), 64'(m_mode != 0));
            chk("drop_flags", 64'(drop_flags), 64'(m_flags));
            chk("drop_count", 64'(drop_count), 64'(m_drops));
            chk("word_count", 64'(word_count), 64'(m_words));

            if (clr) begin
                model_reset();
            end else begin
                any_p = 1'b0;
                for (int k = 0; k < N; k++) begin
                    pre[k] = m_pend[k];
                    any_p |= m_pend[k];
                end
                nd = 0;
                if (g >= 0) begin
                    m_pend[g] = 1'b0;
                    m_last = g;
                    m_words = m_words + 1;
                end
                if (m_mode == 1) begin
                    for (int k = 0; k < N; k++) begin
                        if (bus.ch_valid[k]) begin
                            if (!pre[k] || g == k) begin
                                m_pend[k] = 1'b1;
                                m_hold[k] = bus.ch_timestamp[k*TW +: TW];
                            end else begin
                                m_flags[k] = 1'b1;
                                nd++;
                            end
                        end
                    end
                end
                m_drops = m_drops + nd;
                if (m_drops > 64'hFFFF_FFFF) m_drops = 64'hFFFF_FFFF;
                case (m_mode)
                    0: if (enable) m_mode = 1;
                    1: if (!enable) m_mode = 2;
                    default: begin
                        if (enable) m_mode = 1;
                        else if (!any_p && g < 0) m_mode = 0;
                    end
                endcase
            end
        end
    end

    task automatic set_ts(input int k, input logic [TW-1:0] ts);
        bus.ch_timestamp[k*TW +: TW] = ts;
    endtask

    initial begin
        int nw;
        bus.ch_valid = '0;
        bus.ch_timestamp = '0;
        bus.fifo_full = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        enable = 1'b1;
        tick();

        // single event on ch2
        set_ts(2, 56'h1234);
        bus.ch_valid = 4'b0100;
        tick();
        bus.ch_valid = '0;
        chk("t1_wr_en", 64'(bus.fifo_wr_en), 64'd1);
        chk("t1_din", bus.fifo_din, 64'h0200_0000_0000_1234);
        tick();
        chk("t1_word_count", 64'(word_count), 64'd1);
        chk("t1_drop_count", 64'(drop_count), 64'd0);

        // clear so the pointer starts from ch0, then two simultaneous bursts
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < N; k++) set_ts(k, TW'(k + 1));
            bus.ch_valid = 4'b1111;
            tick();
            bus.ch_valid = '0;
            for (int k = 0; k < N; k++) begin
                chk("t2_order", bus.fifo_din, {8'(k), TW'(k + 1)});
                tick();
            end
        end
        chk("t2_word_count", 64'(word_count), 64'd8);

        // full FIFO: first ch1 event held, next two dropped
        bus.fifo_full = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c % 3 == 0 && c < 9) begin
                set_ts(1, TW'(56'hAAA1 + c / 3));
                bus.ch_valid = 4'b0010;
            end else begin
                bus.ch_valid = '0;
            end
            tick();
        end
        bus.ch_valid = '0;
        chk("t3_drop_flags", 64'(drop_flags), 64'h2);
        chk("t3_drop_count", 64'(drop_count), 64'd2);
        bus.fifo_full = 1'b0;
        #1;
        chk("t3_release_din", bus.fifo_din, 64'h0100_0000_0000_AAA1);
        tick();
        tick();

        // ch0 every cycle alone: no drops
        for (int c = 0; c < 20; c++) begin
            set_ts(0, TW'(c + 100));
            bus.ch_valid = 4'b0001;
            tick();
        end
        bus.ch_valid = '0;
        tick();
        tick();
        chk("t4_word_count", 64'(word_count), 64'd29);
        chk("t4_drop_count", 64'(drop_count), 64'd2);

        // ch0 and ch3 every cycle: alternating grants, one drop per cycle after the first
        for (int c = 0; c < 10; c++) begin
            set_ts(0, TW'(c + 200));
            set_ts(3, TW'(c + 300));
            bus.ch_valid = 4'b1001;
            tick();
        end
        bus.ch_valid = '0;
        repeat (3) tick();
        chk("t4_pair_drop_count", 64'(drop_count), 64'd11);
        chk("t4_pair_word_count", 64'(word_count), 64'd40);

        // drain with pending entries behind a full FIFO
        bus.fifo_full = 1'b1;
        set_ts(1, 56'h11);
        set_ts(2, 56'h22);
        bus.ch_valid = 4'b0110;
        tick();
        bus.ch_valid = '0;
        enable = 1'b0;
        tick();
        chk("t5_busy_drain", 64'(busy), 64'd1);
        bus.ch_valid = 4'b1111;
        tick();
        bus.ch_valid = '0;
        tick();
        chk("t5_drop_ignored", 64'(drop_count), 64'd11);
        bus.fifo_full = 1'b0;
        #1;
        nw = 0;
        for (int c = 0; c < 10 && busy; c++) begin
            if (bus.fifo_wr_en) nw++;
            tick();
        end
        chk("t5_drain_writes", 64'(nw), 64'd2);
        chk("t5_idle", 64'(busy), 64'd0);
        bus.ch_valid = 4'b1111;
        tick();
        bus.ch_valid = '0;
        tick();
        chk("t5_idle_ignore", 64'(word_count), 64'd42);

        // clear with entries pending
        enable = 1'b1;
        tick();
        bus.fifo_full = 1'b1;
        bus.ch_valid = 4'b0111;
        tick();
        bus.ch_valid = '0;
        clr = 1'b1;
        bus.fifo_full = 1'b0;
        tick();
        clr = 1'b0;
        chk("t6_clr_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        chk("t6_clr_drop_count", 64'(drop_count), 64'd0);
        chk("t6_clr_word_count", 64'(word_count), 64'd0);
        chk("t6_clr_drop_flags", 64'(drop_flags), 64'd0);
        chk("t6_clr_busy", 64'(busy), 64'd0);
        tick();

        // asynchronous reset in the middle of a burst
        bus.ch_valid = 4'b1111;
        tick();
        bus.ch_valid = '0;
        chk("t6_burst_wr_en", 64'(bus.fifo_wr_en), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end
endmodule
